soc_full: RTL and testbench

- Top-level self-contained demo SoC for the FPGA build.
- Integrates:
  - a combined reset controller: hard reset pin plus soft-reset button on gpio_in[0];
  - a GPIO status block;
  - an 8N1 UART transmitter and receiver;
  - a fixed boot-banner sequencer.
- After reset the block transmits the banner "OK\r\n" on uart_tx, then echoes every correctly framed byte received on uart_rx.

---
 rtl/soc_full.sv | 362 ++++++++++++++++++++++++++++++++++++
 tb/tb_soc_full.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_full.sv
// soc_full: self-contained demo SoC for the FPGA build.
// It contains:
//   - a hard/soft reset combiner;
//   - a GPIO status block with a heartbeat;
//   - an 8N1 UART transmitter and receiver;
//   - a boot-banner sequencer.
// After reset it sends "OK\r\n", then echoes every byte it receives.
module soc_full #(
    parameter int CLK_DIV = 16,
    parameter int HB_BITS = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] externalPins_gpio_in,
    input  logic       externalPins_uart_rx,
    output logic [5:0] externalPins_gpio_out,
    output logic       externalPins_uart_tx
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
    localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [HB_BITS-1:0] HB_ZERO = {HB_BITS{1'b0}};
    localparam logic [HB_BITS-1:0] HB_ONE  = {{(HB_BITS-1){1'b0}}, 1'b1};
    localparam logic [HB_BITS-1:0] HB_MAX  = {HB_BITS{1'b1}};

    typedef enum logic [1:0] {
        SEQ_BANNER = 2'd0,
        SEQ_LAST   = 2'd1,
        SEQ_ECHO   = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Banner ROM: "OK\r\n"
    function automatic logic [7:0] banner_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    banner_byte = 8'h4F;
            2'd1:    banner_byte = 8'h4B;
            2'd2:    banner_byte = 8'h0D;
            2'd3:    banner_byte = 8'h0A;
            default: banner_byte = 8'h00;
        endcase
    endfunction

    // Synchronisers
    logic [2:0] gpio_meta_r;
    logic [2:0] gpio_sync_r;
    logic       rx_meta_r;
    logic       rx_sync_r;
    logic [1:0] rx_fill_r;
    logic       srst_s;
    logic       unused_s;

    // TX
    logic             tx_line_r;
    logic             tx_busy_r;
    logic [DIV_W-1:0] tx_div_r;
    logic [3:0]       tx_bit_r;
    logic [8:0]       tx_shift_r;
    logic             tx_frame_end_s;
    logic             tx_ready_s;
    logic             tx_start_s;
    logic [7:0]       tx_data_s;

    // Sequencer
    seq_state_t seq_r;
    logic [1:0] byte_idx_r;
    logic       banner_done_r;
    logic       echo_take_s;

    // RX
    rx_state_t        rx_st_r;
    logic [DIV_W-1:0] rx_div_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_shift_r;
    logic             rx_armed_r;
    logic             rx_valid_r;
    logic             rx_ferr_r;

    // Echo buffer and status
    logic         buf_full_r;
    logic [7:0]   buf_data_r;
    logic         err_r;
    logic         rx_tog_r;
    logic [HB_BITS-1:0] hb_cnt_r;
    logic         hb_r;

    assign unused_s = externalPins_gpio_in[3];
    assign srst_s   = gpio_sync_r[0];

    // Two-flop input synchronisers.
    // They are cleared by the reset pin only, so the soft-reset button can itself be sampled.
    // rx_fill_r marks when the rx chain holds real pin samples rather than its reset value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gpio_meta_r <= 3'b000;
            gpio_sync_r <= 3'b000;
            rx_meta_r   <= 1'b1;
            rx_sync_r   <= 1'b1;
            rx_fill_r   <= 2'b00;
        end else begin
            gpio_meta_r <= externalPins_gpio_in[2:0];
            gpio_sync_r <= gpio_meta_r;
            rx_meta_r   <= externalPins_uart_rx;
            rx_sync_r   <= rx_meta_r;
            rx_fill_r   <= {rx_fill_r[0], 1'b1};
        end
    end

    assign tx_frame_end_s = tx_busy_r && (tx_div_r == DIV_LAST) && (tx_bit_r == 4'd9);
    assign tx_ready_s     = !tx_busy_r || tx_frame_end_s;

    // UART transmitter.
    // A new frame may start in the last cycle of a stop bit, so frames can run back-to-back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_line_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_div_r   <= DIV_ZERO;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= 9'h1FF;
        end else if (srst_s) begin
            tx_line_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_div_r   <= DIV_ZERO;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= 9'h1FF;
        end else if (tx_start_s) begin
            tx_line_r  <= 1'b0;
            tx_busy_r  <= 1'b1;
            tx_div_r   <= DIV_ZERO;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= {1'b1, tx_data_s};
        end else if (tx_busy_r) begin
            if (tx_div_r == DIV_LAST) begin
                tx_div_r <= DIV_ZERO;
                if (tx_bit_r == 4'd9) begin
                    tx_busy_r <= 1'b0;
                    tx_line_r <= 1'b1;
                    tx_bit_r  <= 4'd0;
                end else begin
                    tx_bit_r   <= tx_bit_r + 4'd1;
                    tx_line_r  <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                end
            end else begin
                tx_div_r <= tx_div_r + DIV_ONE;
            end
        end else begin
            tx_line_r <= 1'b1;
        end
    end

    // Decide what the transmitter sends next: a banner byte, or the buffered echo byte.
    always_comb begin
        tx_start_s  = 1'b0;
        tx_data_s   = 8'h00;
        echo_take_s = 1'b0;
        case (seq_r)
            SEQ_BANNER: begin
                if (tx_ready_s) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = banner_byte(byte_idx_r);
                end else begin
                    tx_start_s = 1'b0;
                    tx_data_s  = 8'h00;
                end
            end
            SEQ_ECHO: begin
                if (buf_full_r && !tx_busy_r) begin
                    tx_start_s  = 1'b1;
                    tx_data_s   = buf_data_r;
                    echo_take_s = 1'b1;
                end else begin
                    tx_start_s  = 1'b0;
                    tx_data_s   = 8'h00;
                    echo_take_s = 1'b0;
                end
            end
            default: begin
                tx_start_s  = 1'b0;
                tx_data_s   = 8'h00;
                echo_take_s = 1'b0;
            end
        endcase
    end

    // Banner sequencer: queue 4 banner bytes, wait for the last stop bit, then enter echo mode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq_r         <= SEQ_BANNER;
            byte_idx_r    <= 2'd0;
            banner_done_r <= 1'b0;
        end else if (srst_s) begin
            seq_r         <= SEQ_BANNER;
            byte_idx_r    <= 2'd0;
            banner_done_r <= 1'b0;
        end else begin
            case (seq_r)
                SEQ_BANNER: begin
                    if (tx_ready_s) begin
                        if (byte_idx_r == 2'd3) begin
                            seq_r <= SEQ_LAST;
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end
                end
                SEQ_LAST: begin
                    if (tx_frame_end_s) begin
                        banner_done_r <= 1'b1;
                        seq_r         <= SEQ_ECHO;
                    end
                end
                SEQ_ECHO: seq_r <= SEQ_ECHO;
                default:  seq_r <= SEQ_BANNER;
            endcase
        end
    end

    // UART receiver.
    // It arms only after a real high sample, re-checks the start bit at mid-bit, and samples every CLK_DIV cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_st_r    <= RX_IDLE;
            rx_div_r   <= DIV_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_armed_r <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else if (srst_s) begin
            rx_st_r    <= RX_IDLE;
            rx_div_r   <= DIV_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_armed_r <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            if (rx_sync_r && rx_fill_r[1]) begin
                rx_armed_r <= 1'b1;
            end
            case (rx_st_r)
                RX_IDLE: begin
                    if (rx_armed_r && !rx_sync_r) begin
                        rx_st_r  <= RX_START;
                        rx_div_r <= DIV_ZERO;
                    end
                end
                RX_START: begin
                    if (rx_div_r == HALF_LAST) begin
                        rx_div_r <= DIV_ZERO;
                        if (rx_sync_r) begin
                            rx_st_r <= RX_IDLE;
                        end else begin
                            rx_st_r  <= RX_DATA;
                            rx_bit_r <= 3'd0;
                        end
                    end else begin
                        rx_div_r <= rx_div_r + DIV_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_div_r == DIV_LAST) begin
                        rx_div_r   <= DIV_ZERO;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_st_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_div_r <= rx_div_r + DIV_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_div_r == DIV_LAST) begin
                        rx_div_r <= DIV_ZERO;
                        if (rx_sync_r) begin
                            rx_valid_r <= 1'b1;
                            rx_st_r    <= RX_IDLE;
                        end else begin
                            rx_ferr_r <= 1'b1;
                            rx_st_r   <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_div_r <= rx_div_r + DIV_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_r) begin
                        rx_st_r <= RX_IDLE;
                    end
                end
                default: rx_st_r <= RX_IDLE;
            endcase
        end
    end

    // One-entry echo buffer, sticky error flag and the per-byte toggle.
    // A byte that arrives while the buffer drains is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_full_r <= 1'b0;
            buf_data_r <= 8'h00;
            err_r      <= 1'b0;
            rx_tog_r   <= 1'b0;
        end else if (srst_s) begin
            buf_full_r <= 1'b0;
            buf_data_r <= 8'h00;
            err_r      <= 1'b0;
            rx_tog_r   <= 1'b0;
        end else begin
            if (rx_valid_r) begin
                rx_tog_r <= ~rx_tog_r;
                if (!buf_full_r || echo_take_s) begin
                    buf_full_r <= 1'b1;
                    buf_data_r <= rx_shift_r;
                end else begin
                    err_r <= 1'b1;
                end
            end else if (echo_take_s) begin
                buf_full_r <= 1'b0;
            end
            if (rx_ferr_r) begin
                err_r <= 1'b1;
            end
        end
    end

    // Heartbeat: toggle each time the free-running counter wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hb_cnt_r <= HB_ZERO;
            hb_r     <= 1'b0;
        end else if (srst_s) begin
            hb_cnt_r <= HB_ZERO;
            hb_r     <= 1'b0;
        end else begin
            hb_cnt_r <= hb_cnt_r + HB_ONE;
            if (hb_cnt_r == HB_MAX) begin
                hb_r <= ~hb_r;
            end
        end
    end

    assign externalPins_gpio_out = {gpio_sync_r[2:1], rx_tog_r, err_r, banner_done_r, hb_r};
    assign externalPins_uart_tx  = tx_line_r;

endmodule

// File: tb/tb_soc_full.sv
// Directed testbench for soc_full.
// It covers banner, timing, heartbeat, echo, framing error, overrun, soft reset and break.
`timescale 1ns/1ps
module tb_soc_full;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] gpio_in = 4'b0000;
    logic       uart_rx = 1'b1;
    logic [5:0] gpio_out;
    logic       uart_tx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] banner_exp [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};

    soc_full #(.CLK_DIV(16), .HB_BITS(12)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .externalPins_gpio_in  (gpio_in),
        .externalPins_uart_rx  (uart_rx),
        .externalPins_gpio_out (gpio_out),
        .externalPins_uart_tx  (uart_tx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive one frame on uart_rx; caller must be at a negedge.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit, output int c0);
        uart_rx = 1'b0;
        c0 = cyc;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (16) @(negedge clock);
        end
        uart_rx = stop_bit;
        repeat (16) @(negedge clock);
        uart_rx = 1'b1;
    endtask

    // Wait (bounded) for a start bit on uart_tx and decode the frame at mid-bit points.
    task automatic rx_frame(input int max_wait, output logic [7:0] data, output logic stop_v,
                            output int sc, output bit got);
        int n;
        got = 1'b0;
        data = 8'h00;
        stop_v = 1'b0;
        sc = -1;
        n = 0;
        while (!got && n < max_wait) begin
            @(posedge clock);
            #1;
            n++;
            if (uart_tx === 1'b0) begin
                got = 1'b1;
                sc = cyc;
            end
        end
        if (got) begin
            repeat (8) @(posedge clock);
            #1;
            for (int b = 0; b < 8; b++) begin
                repeat (16) @(posedge clock);
                #1;
                data[b] = uart_tx;
            end
            repeat (16) @(posedge clock);
            #1;
            stop_v = uart_tx;
        end
    endtask

    initial begin
        int rel;
        int c0;
        int c1;
        int sc;
        int prev;
        logic [7:0] d;
        logic sv;
        bit got;

        // Hard reset with idle rx line
        tick(10);
        chk("rst_tx", uart_tx, 1);
        chk("rst_gpio", gpio_out, 6'b000000);
        @(negedge clock);
        reset = 1'b1;
        rel = cyc;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            rx_frame(200, d, sv, sc, got);
            chk("banner_got", got, 1);
            chk("banner_byte", d, banner_exp[k]);
            chk("banner_stop", sv, 1);
            if (k == 0) chk("banner_start", sc, rel + 1);
            else chk("banner_gap", sc, prev + 160);
            prev = sc;
        end
        wait_until(rel + 640);
        chk("done_early", gpio_out[1], 0);
        wait_until(rel + 641);
        chk("done_set", gpio_out[1], 1);
        chk("idle_tx", uart_tx, 1);
        chk("no_err_tog", gpio_out[3:2], 2'b00);
        wait_until(rel + 4095);
        chk("hb_before", gpio_out[0], 0);
        wait_until(rel + 4096);
        chk("hb_toggle", gpio_out[0], 1);

        // Echo of 0xA5
        @(negedge clock);
        fork
            send_byte(8'hA5, 1'b1, c0);
            rx_frame(400, d, sv, sc, got);
        join
        chk("echo_got", got, 1);
        chk("echo_byte", d, 8'hA5);
        chk("echo_stop", sv, 1);
        chk_range("echo_latency", sc - c0, 154, 158);
        chk("echo_tog", gpio_out[3], 1);
        chk("echo_err", gpio_out[2], 0);

        // Framing error: no echo, sticky error
        @(negedge clock);
        fork
            send_byte(8'h81, 1'b0, c0);
            rx_frame(300, d, sv, sc, got);
        join
        chk("ferr_no_echo", got, 0);
        chk("ferr_err", gpio_out[2], 1);
        chk("ferr_tog", gpio_out[3], 1);
        tick(200);
        chk("ferr_sticky", gpio_out[2], 1);

        // Soft reset pulse with switches = 2'b10
        @(negedge clock);
        gpio_in = 4'b0100;
        tick(4);
        chk("sw_pass", gpio_out[5:4], 2'b10);
        @(negedge clock);
        gpio_in = 4'b0101;
        tick(5);
        chk("srst_clr", gpio_out[3:0], 4'b0000);
        chk("srst_sw", gpio_out[5:4], 2'b10);
        chk("srst_tx", uart_tx, 1);
        repeat (95) @(negedge clock);
        chk("srst_late", gpio_out, 6'b100000);
        gpio_in = 4'b0100;
        c0 = cyc;
        fork
            begin
                rx_frame(50, d, sv, sc, got);
                chk("replay_start", sc, c0 + 3);
                chk("replay_b0", d, 8'h4F);
                for (int k = 1; k < 4; k++) begin
                    rx_frame(200, d, sv, sc, got);
                    chk("replay_byte", d, banner_exp[k]);
                end
            end
            begin
                repeat (20) @(negedge clock);
                send_byte(8'h3C, 1'b1, c1);
                chk("ovr_tog1", gpio_out[3], 1);
                chk("ovr_err0", gpio_out[2], 0);
                send_byte(8'h5A, 1'b1, c1);
                repeat (3) @(negedge clock);
                chk("ovr_err1", gpio_out[2], 1);
                chk("ovr_tog2", gpio_out[3], 0);
                chk("ovr_sw", gpio_out[5:4], 2'b10);
                chk("ovr_notdone", gpio_out[1], 0);
            end
        join
        rx_frame(200, d, sv, sc, got);
        chk("ovr_echo_got", got, 1);
        chk("ovr_echo_byte", d, 8'h3C);
        chk("ovr_done", gpio_out[1], 1);
        rx_frame(300, d, sv, sc, got);
        chk("ovr_dropped", got, 0);

        // Break: rx held low through and after reset
        @(negedge clock);
        gpio_in = 4'b0000;
        uart_rx = 1'b0;
        reset = 1'b0;
        tick(10);
        chk("brk_rst_tx", uart_tx, 1);
        chk("brk_rst_gpio", gpio_out, 6'b000000);
        @(negedge clock);
        reset = 1'b1;
        rel = cyc;
        for (int k = 0; k < 4; k++) begin
            rx_frame(200, d, sv, sc, got);
            chk("brk_byte", d, banner_exp[k]);
            chk("brk_quiet", gpio_out[3:2], 2'b00);
        end
        wait_until(rel + 700);
        chk("brk_quiet_end", gpio_out[3:2], 2'b00);
        chk("brk_done", gpio_out[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
